// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency ROM reads and
// buffers {pc, instr} pairs in a small queue handed to decode via valid/ready.
module fetch_unit #(
  parameter int          ADDR_W   = 16,
  parameter int          INSTR_W  = 16,
  parameter int          QDEPTH   = 4,
  parameter int          PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr_out,
  output logic [ADDR_W-1:0]        pc_out,
  output logic [$clog2(QDEPTH):0]  q_count
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W+1)'(QDEPTH);

  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  inflight_pc_r;
  logic               inflight_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [ADDR_W-1:0]  pc_mem_r    [QDEPTH];
  logic [INSTR_W-1:0] instr_mem_r [QDEPTH];
  logic [CNT_W:0]     occ_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;

  // Credit counts the in-flight read so a response always finds a free slot.
  always_comb begin
    occ_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    if (reset || redirect_valid) begin
      issue_s = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
    end else begin
      issue_s = ~halt & (occ_s < DEPTH_C);
      push_s  = inflight_r;
      pop_s   = (count_r != {CNT_W{1'b0}}) & instr_ready;
    end
  end

  // PC, in-flight tracking and queue pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC_C;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      pc_r       <= redirect_pc;
      inflight_r <= 1'b0;
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        pc_r          <= pc_r + STEP_C;
        inflight_pc_r <= pc_r;
      end
      inflight_r <= issue_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage needs no reset: occupancy qualifies every entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
      instr_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

  assign imem_req    = issue_s;
  assign imem_addr   = pc_r;
  assign instr_valid = (count_r != {CNT_W{1'b0}});
  assign instr_out   = instr_mem_r[rd_ptr_r];
  assign pc_out      = pc_mem_r[rd_ptr_r];
  assign q_count     = count_r;

  fetch_unit_chk #(.CNT_W(CNT_W), .QDEPTH(QDEPTH)) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );
endmodule

// Protocol checker: a push without a pop must never meet a full queue.
module fetch_unit_chk #(
  parameter int CNT_W  = 3,
  parameter int QDEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(QDEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push && !pop) |-> (count != FULL_C));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect, halt,
// mid-run reset and PC wrap (second instance with RESET_PC near the top).
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, halt, redirect_valid, instr_ready;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_out;
  logic        imem_req, instr_valid;
  logic [2:0]  q_count;

  logic        reset2;
  logic [15:0] imem_addr2, imem_rdata2, instr_out2, pc_out2;
  logic        imem_req2, instr_valid2;
  logic [2:0]  q_count2;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_pc;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .QDEPTH(4), .PC_STEP(1), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .q_count(q_count)
  );

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .QDEPTH(4), .PC_STEP(1), .RESET_PC(32'hFFFE)) dut2 (
    .clk(clk), .reset(reset2), .halt(1'b0), .redirect_valid(1'b0),
    .redirect_pc(16'h0000), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr_out(instr_out2), .pc_out(pc_out2), .q_count(q_count2)
  );

  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // ROM models: 1-cycle latency, poison value when no read was issued
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? rom(imem_addr)  : 16'hDEAD;
    imem_rdata2 <= imem_req2 ? rom(imem_addr2) : 16'hDEAD;
  end

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (q_count !== 3'd0) begin n_bad++; $display("FAIL reset_q_count: got %0d want 0", q_count); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    reset = 1'b0;
    instr_ready = 1'b1;
  endtask

  task automatic test_stream();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(c-1)) begin
        n_bad++; $display("FAIL stream_issue c%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, 16'(c-1));
      end
      n_cmp++;
      if (c < 3) begin
        if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_latency c%0d: got valid=%b want 0", c, instr_valid); end
      end else if (instr_valid !== 1'b1 || pc_out !== 16'(c-3) || instr_out !== rom(16'(c-3))) begin
        n_bad++; $display("FAIL stream_head c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", c, instr_valid, pc_out, instr_out, 16'(c-3), rom(16'(c-3)));
      end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (q_count !== 3'd4) begin n_bad++; $display("FAIL bp_full: got %0d want 4", q_count); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 16'h0005 || instr_out !== 16'hA005) begin
      n_bad++; $display("FAIL bp_head_stable: got v=%b pc=%h i=%h want v=1 pc=0005 i=a005", instr_valid, pc_out, instr_out);
    end
    instr_ready = 1'b1;
    exp_pc = 16'h0005;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || pc_out !== exp_pc || instr_out !== rom(exp_pc)) begin
        n_bad++; $display("FAIL bp_drain %0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, instr_valid, pc_out, instr_out, exp_pc, rom(exp_pc));
      end
      exp_pc = exp_pc + 16'h0001;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_redirect();
    int k;
    instr_ready = 1'b0;
    k = 0;
    while (q_count !== 3'd3 && k < 8) begin
      @(negedge clk); #1; k++;
    end
    n_cmp++; if (q_count !== 3'd3) begin n_bad++; $display("FAIL redir_setup: got q_count=%0d want 3", q_count); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_no_req: got %b want 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got q=%0d v=%b want q=0 v=0", q_count, instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_bad++; $display("FAIL redir_issue: got req=%b addr=%h want 1 0040", imem_req, imem_addr); end
    instr_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_stale: got v=%b pc=%h want v=0", instr_valid, pc_out); end
    exp_pc = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (instr_valid !== 1'b1 || pc_out !== exp_pc || instr_out !== rom(exp_pc)) begin
        n_bad++; $display("FAIL redir_target %0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, instr_valid, pc_out, instr_out, exp_pc, rom(exp_pc));
      end
      exp_pc = exp_pc + 16'h0001;
    end
  endtask

  task automatic test_halt();
    int seen;
    seen = 0;
    @(negedge clk);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_req %0d: got %b want 0", i, imem_req); end
      if (instr_valid === 1'b1) begin
        n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL halt_order %0d: got pc=%h want %h", i, pc_out, exp_pc); end
        exp_pc = exp_pc + 16'h0001;
        seen++;
      end
    end
    n_cmp++; if (seen != 2) begin n_bad++; $display("FAIL halt_trailing: got %0d heads want 2", seen); end
    @(negedge clk);
    halt = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_bad++; $display("FAIL halt_resume: got req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (instr_valid === 1'b1) begin
        n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL halt_resume_order %0d: got pc=%h want %h", i, pc_out, exp_pc); end
        exp_pc = exp_pc + 16'h0001;
        seen++;
      end
    end
    n_cmp++; if (seen != 6) begin n_bad++; $display("FAIL halt_resume_count: got %0d want 6", seen); end
  endtask

  task automatic test_mid_reset();
    int k;
    instr_ready = 1'b0;
    k = 0;
    while (q_count !== 3'd2 && k < 8) begin
      @(negedge clk); #1; k++;
    end
    n_cmp++; if (q_count !== 3'd2) begin n_bad++; $display("FAIL mreset_setup: got q_count=%0d want 2", q_count); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (instr_valid !== 1'b0 || q_count !== 3'd0) begin n_bad++; $display("FAIL mreset_clear: got v=%b q=%0d want 0 0", instr_valid, q_count); end
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin n_bad++; $display("FAIL mreset_pc: got req=%b addr=%h want 0 0000", imem_req, imem_addr); end
    reset = 1'b0;
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mreset_restart: got req=%b want 1", imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mreset_drop: got v=%b pc=%h want v=0", instr_valid, pc_out); end
    @(negedge clk); #1;
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 16'h0000 || instr_out !== 16'hA000) begin
      n_bad++; $display("FAIL mreset_first: got v=%b pc=%h i=%h want 1 0000 a000", instr_valid, pc_out, instr_out);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    @(negedge clk);
    reset2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (c == 1) begin
        n_cmp++; if (q_count2 !== 3'd0) begin n_bad++; $display("FAIL wrap_q0: got %0d want 0", q_count2); end
      end
      if (c <= 4) begin
        e = 16'hFFFE + 16'(c-1);
        n_cmp++; if (imem_addr2 !== e) begin n_bad++; $display("FAIL wrap_addr c%0d: got %h want %h", c, imem_addr2, e); end
      end
      if (c >= 3) begin
        e = 16'hFFFE + 16'(c-3);
        n_cmp++;
        if (instr_valid2 !== 1'b1 || pc_out2 !== e || instr_out2 !== rom(e)) begin
          n_bad++; $display("FAIL wrap_head c%0d: got v=%b pc=%h i=%h want 1 %h %h", c, instr_valid2, pc_out2, instr_out2, e, rom(e));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
